// File: rtl/riscv_hazard_unit_if.sv
// ============================================================================
// Module  : riscv_hazard_unit_if
// Purpose : Pipeline-side bundle for riscv_hazard_unit (register indices,
//           write enables, branch resolution, forwarding/stall/flush controls).
//           RISCV_HAZARD_PERF_EN adds the stall/flush performance counters.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface riscv_hazard_unit_if #(
    parameter int INDEX = 5
`ifdef RISCV_HAZARD_PERF_EN
    ,
    parameter int CNT_W = 32
`endif
);
    logic             id_valid_in;
    logic [INDEX-1:0] id_rs1_in;
    logic [INDEX-1:0] id_rs2_in;
    logic [INDEX-1:0] ex_rs1_in;
    logic [INDEX-1:0] ex_rs2_in;
    logic [INDEX-1:0] ex_rd_in;
    logic             ex_mem_read_in;
    logic [INDEX-1:0] mem_rd_in;
    logic             mem_reg_write_in;
    logic [INDEX-1:0] wb_rd_in;
    logic             wb_reg_write_in;
    logic             branch_taken_in;
    logic [1:0]       fwd_a_out;
    logic [1:0]       fwd_b_out;
    logic             stall_pc_out;
    logic             stall_ifid_out;
    logic             bubble_idex_out;
    logic             flush_ifid_out;
    logic             flush_idex_out;
    logic             flush_exmem_out;
`ifdef RISCV_HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt_out;
    logic [CNT_W-1:0] flush_cnt_out;
`endif

    // Pipeline side: supplies stage state, consumes hazard controls
    modport master (
`ifdef RISCV_HAZARD_PERF_EN
        input  stall_cnt_out, flush_cnt_out,
`endif
        output id_valid_in, id_rs1_in, id_rs2_in, ex_rs1_in, ex_rs2_in, ex_rd_in,
        output ex_mem_read_in, mem_rd_in, mem_reg_write_in, wb_rd_in, wb_reg_write_in,
        output branch_taken_in,
        input  fwd_a_out, fwd_b_out, stall_pc_out, stall_ifid_out, bubble_idex_out,
        input  flush_ifid_out, flush_idex_out, flush_exmem_out
    );

    modport slave (
`ifdef RISCV_HAZARD_PERF_EN
        output stall_cnt_out, flush_cnt_out,
`endif
        input  id_valid_in, id_rs1_in, id_rs2_in, ex_rs1_in, ex_rs2_in, ex_rd_in,
        input  ex_mem_read_in, mem_rd_in, mem_reg_write_in, wb_rd_in, wb_reg_write_in,
        input  branch_taken_in,
        output fwd_a_out, fwd_b_out, stall_pc_out, stall_ifid_out, bubble_idex_out,
        output flush_ifid_out, flush_idex_out, flush_exmem_out
    );
endinterface

`default_nettype wire

// File: rtl/riscv_hazard_unit.sv
// ============================================================================
// Module  : riscv_hazard_unit
// Purpose : EX operand forwarding, LOAD_LAT-cycle load-use stall and taken-branch
//           squash for the 5-stage pipeline. Optional RISCV_HAZARD_PERF_EN adds
//           saturating stall/flush cycle counters.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module riscv_hazard_unit #(
    parameter int INDEX    = 5,
    parameter int LOAD_LAT = 1
`ifdef RISCV_HAZARD_PERF_EN
    ,
    parameter int CNT_W    = 32
`endif
) (
    input  wire logic          clk_in,
    input  wire logic          rst_in,
    riscv_hazard_unit_if.slave bus
);
    localparam int CW = (LOAD_LAT > 1) ? $clog2(LOAD_LAT + 1) : 1;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          luh;
    logic          stall;
    logic          flush;
    logic [1:0]    fwd_a;
    logic [1:0]    fwd_b;

    function automatic logic [1:0] fwd_sel(
        input logic [INDEX-1:0] rs,
        input logic [INDEX-1:0] mem_rd,
        input logic             mem_wr,
        input logic [INDEX-1:0] wb_rd,
        input logic             wb_wr
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (mem_wr && (mem_rd != '0) && (mem_rd == rs)) begin
            sel = 2'b10;
        end else if (wb_wr && (wb_rd != '0) && (wb_rd == rs)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    always_comb begin
        fwd_a = fwd_sel(bus.ex_rs1_in, bus.mem_rd_in, bus.mem_reg_write_in,
                        bus.wb_rd_in, bus.wb_reg_write_in);
        fwd_b = fwd_sel(bus.ex_rs2_in, bus.mem_rd_in, bus.mem_reg_write_in,
                        bus.wb_rd_in, bus.wb_reg_write_in);
    end

    assign luh = bus.ex_mem_read_in && (bus.ex_rd_in != '0) && bus.id_valid_in &&
                 ((bus.ex_rd_in == bus.id_rs1_in) || (bus.ex_rd_in == bus.id_rs2_in));

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // A taken branch squashes everything younger, including an in-flight stall
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall     = 1'b0;
        flush     = 1'b0;
        if (bus.branch_taken_in) begin
            flush     = 1'b1;
            state_nxt = RUN;
            cnt_nxt   = '0;
        end else begin
            case (state)
                RUN: begin
                    if (luh) begin
                        stall = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_nxt = STALL;
                            cnt_nxt   = CW'(LOAD_LAT - 1);
                        end
                    end
                end
                STALL: begin
                    stall   = 1'b1;
                    cnt_nxt = cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state_nxt = RUN;
                    end
                end
                default: begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Every output, combinational forwarding included, is held low during reset
    assign bus.fwd_a_out       = rst_in ? fwd_a : 2'b00;
    assign bus.fwd_b_out       = rst_in ? fwd_b : 2'b00;
    assign bus.stall_pc_out    = rst_in & stall;
    assign bus.stall_ifid_out  = rst_in & stall;
    assign bus.bubble_idex_out = rst_in & stall;
    assign bus.flush_ifid_out  = rst_in & flush;
    assign bus.flush_idex_out  = rst_in & flush;
    assign bus.flush_exmem_out = rst_in & flush;

`ifdef RISCV_HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.stall_cnt_out = stall_cnt;
    assign bus.flush_cnt_out = flush_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_riscv_hazard_unit.sv
// ============================================================================
// Module  : tb_riscv_hazard_unit
// Purpose : Directed scoreboard bench for riscv_hazard_unit, LOAD_LAT=1 and 3
//           instances driven in lockstep; RISCV_HAZARD_PERF_EN uses CNT_W=4.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_riscv_hazard_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic vld = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] fa;
        logic [1:0] fb;
        logic       st1;
        logic       st3;
        logic       fl;
        logic       pchk;
        logic [3:0] sc;
        logic [3:0] fc;
    } exp_t;

    exp_t q[$];

`ifdef RISCV_HAZARD_PERF_EN
    riscv_hazard_unit_if #(.INDEX(5), .CNT_W(4)) if1 ();
    riscv_hazard_unit_if #(.INDEX(5), .CNT_W(4)) if3 ();
    riscv_hazard_unit #(.INDEX(5), .LOAD_LAT(1), .CNT_W(4)) dut1 (.clk_in(clk), .rst_in(rst_n), .bus(if1));
    riscv_hazard_unit #(.INDEX(5), .LOAD_LAT(3), .CNT_W(4)) dut3 (.clk_in(clk), .rst_in(rst_n), .bus(if3));
`else
    riscv_hazard_unit_if #(.INDEX(5)) if1 ();
    riscv_hazard_unit_if #(.INDEX(5)) if3 ();
    riscv_hazard_unit #(.INDEX(5), .LOAD_LAT(1)) dut1 (.clk_in(clk), .rst_in(rst_n), .bus(if1));
    riscv_hazard_unit #(.INDEX(5), .LOAD_LAT(3)) dut3 (.clk_in(clk), .rst_in(rst_n), .bus(if3));
`endif

    task automatic drive(input int idv, input int irs1, input int irs2, input int ers1,
                         input int ers2, input int erd, input int emr, input int mrd,
                         input int mw, input int wrd, input int ww, input int br);
        if1.id_valid_in = 1'(idv);       if3.id_valid_in = 1'(idv);
        if1.id_rs1_in = 5'(irs1);        if3.id_rs1_in = 5'(irs1);
        if1.id_rs2_in = 5'(irs2);        if3.id_rs2_in = 5'(irs2);
        if1.ex_rs1_in = 5'(ers1);        if3.ex_rs1_in = 5'(ers1);
        if1.ex_rs2_in = 5'(ers2);        if3.ex_rs2_in = 5'(ers2);
        if1.ex_rd_in = 5'(erd);          if3.ex_rd_in = 5'(erd);
        if1.ex_mem_read_in = 1'(emr);    if3.ex_mem_read_in = 1'(emr);
        if1.mem_rd_in = 5'(mrd);         if3.mem_rd_in = 5'(mrd);
        if1.mem_reg_write_in = 1'(mw);   if3.mem_reg_write_in = 1'(mw);
        if1.wb_rd_in = 5'(wrd);          if3.wb_rd_in = 5'(wrd);
        if1.wb_reg_write_in = 1'(ww);    if3.wb_reg_write_in = 1'(ww);
        if1.branch_taken_in = 1'(br);    if3.branch_taken_in = 1'(br);
    endtask

    // One vector per clock: inputs settle just after the edge, monitor samples on negedge
    task automatic vec(input int rst, input int idv, input int irs1, input int irs2,
                       input int ers1, input int ers2, input int erd, input int emr,
                       input int mrd, input int mw, input int wrd, input int ww, input int br,
                       input int efa, input int efb, input int est1, input int est3,
                       input int efl, input int pchk, input int esc, input int efc);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = 1'(rst);
        drive(idv, irs1, irs2, ers1, ers2, erd, emr, mrd, mw, wrd, ww, br);
        e.fa = 2'(efa); e.fb = 2'(efb); e.st1 = 1'(est1); e.st3 = 1'(est3);
        e.fl = 1'(efl); e.pchk = 1'(pchk); e.sc = 4'(esc); e.fc = 4'(efc);
        q.push_back(e);
        vld = 1'b1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (vld) begin
            if (q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL scoreboard_underflow: output sampled with no expected entry");
            end else begin
                e = q.pop_front();
                n_vec++;
                if (if1.fwd_a_out !== e.fa || if1.fwd_b_out !== e.fb ||
                    {if1.stall_pc_out, if1.stall_ifid_out, if1.bubble_idex_out} !== {3{e.st1}} ||
                    {if1.flush_ifid_out, if1.flush_idex_out, if1.flush_exmem_out} !== {3{e.fl}}) begin
                    n_err++;
                    $display("FAIL lat1 @%0t: got fa=%b fb=%b st=%b%b%b fl=%b%b%b, want fa=%b fb=%b st=%b fl=%b",
                             $time, if1.fwd_a_out, if1.fwd_b_out, if1.stall_pc_out, if1.stall_ifid_out,
                             if1.bubble_idex_out, if1.flush_ifid_out, if1.flush_idex_out,
                             if1.flush_exmem_out, e.fa, e.fb, e.st1, e.fl);
                end
                n_vec++;
                if (if3.fwd_a_out !== e.fa || if3.fwd_b_out !== e.fb ||
                    {if3.stall_pc_out, if3.stall_ifid_out, if3.bubble_idex_out} !== {3{e.st3}} ||
                    {if3.flush_ifid_out, if3.flush_idex_out, if3.flush_exmem_out} !== {3{e.fl}}) begin
                    n_err++;
                    $display("FAIL lat3 @%0t: got fa=%b fb=%b st=%b%b%b fl=%b%b%b, want fa=%b fb=%b st=%b fl=%b",
                             $time, if3.fwd_a_out, if3.fwd_b_out, if3.stall_pc_out, if3.stall_ifid_out,
                             if3.bubble_idex_out, if3.flush_ifid_out, if3.flush_idex_out,
                             if3.flush_exmem_out, e.fa, e.fb, e.st3, e.fl);
                end
`ifdef RISCV_HAZARD_PERF_EN
                if (e.pchk) begin
                    n_vec++;
                    if (if1.stall_cnt_out !== e.sc || if3.stall_cnt_out !== e.sc ||
                        if1.flush_cnt_out !== e.fc || if3.flush_cnt_out !== e.fc) begin
                        n_err++;
                        $display("FAIL perf_cnt @%0t: got stall=%0d/%0d flush=%0d/%0d, want stall=%0d flush=%0d",
                                 $time, if1.stall_cnt_out, if3.stall_cnt_out, if1.flush_cnt_out,
                                 if3.flush_cnt_out, e.sc, e.fc);
                    end
                end
`endif
            end
        end
    end

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        //   rst idv rs1 rs2 ers1 ers2 erd emr mrd mw wrd ww br | fa fb s1 s3 fl pc sc fc
        // reset holds every output low even with a forwarding/load-use pattern present
        vec(0, 1, 0, 5, 3, 0, 5, 1, 3, 1, 3, 1, 0,   0, 0, 0, 0, 0, 0, 0, 0);
        // forwarding: MEM beats WB, WB alone, x0 never forwards, both operands
        vec(1, 0, 0, 0, 3, 7, 0, 0, 3, 1, 3, 1, 0,   2, 0, 0, 0, 0, 0, 0, 0);
        vec(1, 0, 0, 0, 3, 7, 0, 0, 3, 0, 3, 1, 0,   1, 0, 0, 0, 0, 0, 0, 0);
        vec(1, 0, 0, 0, 4, 0, 0, 0, 0, 1, 4, 1, 0,   1, 0, 0, 0, 0, 0, 0, 0);
        vec(1, 0, 0, 0, 9, 9, 0, 0, 9, 1, 9, 1, 0,   2, 2, 0, 0, 0, 0, 0, 0);
        vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0, 0, 0, 0);
        // load-use on rs2: 1 stall cycle at LOAD_LAT=1, 3 at LOAD_LAT=3; forwarding unaffected
        vec(1, 1, 1, 5, 0, 0, 5, 1, 0, 0, 0, 0, 0,   0, 0, 1, 1, 0, 0, 0, 0);
        vec(1, 0, 0, 0, 0, 2, 0, 0, 0, 0, 2, 1, 0,   0, 1, 0, 1, 0, 0, 0, 0);
        vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0, 0, 0);
        vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0);
        // no stall: ID slot invalid, or load targets x0
        vec(1, 0, 6, 0, 0, 0, 6, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0);
        vec(1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0);
        // branch in second stall cycle aborts the stall
        vec(1, 1, 5, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0,   0, 0, 1, 1, 0, 0, 0, 0);
        vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 1, 0, 0, 0);
        vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0);
        // branch and load-use together: flush only
        vec(1, 1, 5, 0, 0, 0, 5, 1, 0, 0, 0, 0, 1,   0, 0, 0, 0, 1, 0, 0, 0);
        vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0);
        // reset mid-stall, then release back into RUN
        vec(1, 1, 5, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0,   0, 0, 1, 1, 0, 0, 0, 0);
        vec(0, 0, 0, 0, 3, 0, 0, 0, 3, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0);
        vec(1, 0, 0, 0, 3, 0, 0, 0, 3, 1, 0, 0, 0,   2, 0, 0, 0, 0, 1, 0, 0);
        // 20 back-to-back stall cycles saturate a 4-bit counter at 15
        for (int i = 0; i < 20; i++) begin
            vec(1, 1, 0, 5, 0, 0, 5, 1, 0, 0, 0, 0, 0,   0, 0, 1, 1, 0, 0, 0, 0);
        end
        vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 1, 1, 15, 0);
        vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1, 15, 1);
        @(posedge clk);
        #1;
        vld = 1'b0;
        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

`default_nettype wire
